// File: rtl/scc_pkg.sv
// Shared constants for the instruction-memory server: word width, NOP word
// and the RUN/LOAD state encoding.
package scc_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = '0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Unreset instruction storage: one synchronous write port, one registered read port.
module imem_array
  import scc_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Enable-gated registered read so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_server.sv
// Instruction fetch server: RUN/LOAD control, address checks and a fixed
// LATENCY return pipeline in front of the instruction array.
module imem_server
  import scc_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [WORD_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              flush,
  input  logic              load_en,
  input  logic [31:0]       load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Misaligned, or any byte-address bit above the array range set.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (|a[31:AW+2]);
  endfunction

  state_t            state_reg;
  state_t            state_next;
  logic              fetch_accept;
  logic              fetch_bad;
  logic              load_bad;
  logic              load_we;
  logic              load_err_reg;
  logic [WORD_W-1:0] array_rdata;
  logic [WORD_W-1:0] out_data;
  logic [LATENCY-1:0] valid_reg;
  logic [LATENCY-1:0] fault_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // LOAD hands back to RUN in the very cycle load_en drops, so a fetch can
  // follow a load write immediately.
  always_comb begin
    state_next  = state_reg;
    fetch_ready = 1'b1;
    case (state_reg)
      ST_RUN: begin
        if (load_en) begin
          state_next  = ST_LOAD;
          fetch_ready = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_en) begin
          fetch_ready = 1'b0;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign fetch_accept = fetch_req && fetch_ready;
  assign fetch_bad    = addr_bad(fetch_addr);
  assign load_bad     = addr_bad(load_addr);
  assign load_we      = load_en && !load_bad;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_we),
    .waddr (load_addr[AW+1:2]),
    .wdata (load_data),
    .re    (fetch_accept),
    .raddr (fetch_addr[AW+1:2]),
    .rdata (array_rdata)
  );

  // Stage 0 is loaded unconditionally so a fetch accepted alongside flush survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg    <= '0;
      fault_reg    <= '0;
      load_err_reg <= 1'b0;
    end else begin
      valid_reg[0] <= fetch_accept;
      fault_reg[0] <= fetch_bad;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1] && !flush;
        fault_reg[i] <= fault_reg[i-1];
      end
      load_err_reg <= load_en && load_bad;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign out_data = array_rdata;
    end else begin : g_delay
      logic [WORD_W-1:0] data_reg [LATENCY-1];
      always_ff @(posedge clk) begin
        data_reg[0] <= array_rdata;
        for (int i = 1; i < LATENCY - 1; i++) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
      assign out_data = data_reg[LATENCY-2];
    end
  endgenerate

  assign fetch_valid = valid_reg[LATENCY-1];
  assign fetch_fault = fetch_valid && fault_reg[LATENCY-1];
  assign fetch_instr = (fetch_valid && !fault_reg[LATENCY-1]) ? out_data : NOP_WORD;
  assign load_err    = load_err_reg;

endmodule

// File: tb/tb_imem_server.sv
// Scoreboard bench for imem_server: expected fetch results are queued with
// their due cycle when driven and compared as the DUT returns them.
module tb_imem_server;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_err;

  imem_server #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .flush       (flush),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_mem [DEPTH];
  bit          err_at [int];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_err_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: cycle %0d got fetch_valid=1 instr=%h, required no result", cyc, fetch_instr);
      end else begin
        mon_e = sb.pop_front();
        if (fetch_instr !== mon_e.instr || fetch_fault !== mon_e.fault || cyc != mon_e.due) begin
          errors++;
          $display("FAIL fetch_result addr=%h: got instr=%h fault=%b cycle=%0d, required instr=%h fault=%b cycle=%0d",
                   mon_e.addr, fetch_instr, fetch_fault, cyc, mon_e.instr, mon_e.fault, mon_e.due);
        end else begin
          $display("fetch   addr=%h instr=%h fault=%b cycle=%0d", mon_e.addr, fetch_instr, fetch_fault, cyc);
        end
      end
    end else begin
      checks++;
      if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: cycle %0d got valid=%b instr=%h fault=%b, required 0/0/0", cyc, fetch_valid, fetch_instr, fetch_fault);
      end
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        errors++;
        $display("FAIL missing_result addr=%h: got no fetch_valid by cycle %0d, required at cycle %0d", mon_e.addr, cyc, mon_e.due);
      end
    end
    mon_err_exp = err_at.exists(cyc);
    checks++;
    if (load_err !== mon_err_exp) begin
      errors++;
      $display("FAIL load_err: cycle %0d got %b, required %b", cyc, load_err, mon_err_exp);
    end
  end

  task automatic drive(input logic req, input logic [31:0] addr, input logic fl,
                       input logic ld, input logic [31:0] laddr, input logic [31:0] ldata);
    exp_t e;
    @(posedge clk);
    #1;
    fetch_req  = req;
    fetch_addr = addr;
    flush      = fl;
    load_en    = ld;
    load_addr  = laddr;
    load_data  = ldata;
    if (fl) begin
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end
    if (req && !ld) begin
      e.due  = cyc + LAT;
      e.addr = addr;
      if (addr[1:0] != 2'b00 || addr >= 32'(4 * DEPTH)) begin
        e.fault = 1'b1;
        e.instr = 32'h0;
      end else begin
        e.fault = 1'b0;
        e.instr = model_mem[addr[AW+1:2]];
      end
      sb.push_back(e);
    end
    if (ld) begin
      if (laddr[1:0] != 2'b00 || laddr >= 32'(4 * DEPTH)) begin
        err_at[cyc + 1] = 1'b1;
        $display("load    addr=%h data=%h dropped cycle=%0d", laddr, ldata, cyc);
      end else begin
        model_mem[laddr[AW+1:2]] = ldata;
        $display("load    addr=%h data=%h cycle=%0d", laddr, ldata, cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] addr);
    drive(1'b1, addr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, 32'h0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || fetch_fault !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b instr=%h fault=%b load_err=%b, required all 0",
               fetch_valid, fetch_instr, fetch_fault, load_err);
    end
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", fetch_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom);
    idle(1);
  endtask

  task automatic test_back_to_back();
    load(32'h0, 32'h11111111);
    load(32'h4, 32'h22222222);
    load(32'h8, 32'h33333333);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle(LAT + 1);
  endtask

  task automatic test_fault();
    fetch(32'h6);
    fetch(32'h400);
    fetch(32'h3FC);
    fetch(32'hFFFF_FFFC);
    fetch(32'h3FD);
    idle(LAT + 1);
  endtask

  task automatic test_flush();
    fetch(32'h0);
    idle(1);
    fetch(32'h4);
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(LAT + 2);
  endtask

  task automatic test_load_during_flight();
    fetch(32'h0);
    drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_load: got %b, required 0", fetch_ready);
    end
    fetch(32'h0);
    #1;
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_load: got %b, required 1", fetch_ready);
    end
    idle(LAT + 1);
  endtask

  task automatic test_load_err();
    load(32'h2, 32'hCAFEF00D);
    idle(1);
    load(32'h400, 32'h0BADF00D);
    idle(1);
    fetch(32'h0);
    idle(LAT + 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        rq, fl, ld;
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      rq = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 9) == 0);
      ld = ($urandom_range(0, 14) == 0);
      drive(rq, a, fl, ld, a, $urandom);
    end
    idle(LAT + 2);
  endtask

  task automatic test_reset_midflight();
    fetch(32'h10);
    fetch(32'h14);
    fetch(32'h18);
    idle(1);
    checks++;
    if (fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %b, required 1", fetch_valid);
    end
    #1 reset = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got valid=%b instr=%h fault=%b, required 0/0/0",
               fetch_valid, fetch_instr, fetch_fault);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(LAT + 3);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_back_to_back();
    test_fault();
    test_flush();
    test_load_during_flight();
    test_load_err();
    test_random();
    test_reset_midflight();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d unreturned fetches, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
